// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32 x 32-bit register file.
package regfile_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [DATA_W-1:0]     reg_word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NREGS-1:0]      wr_sel_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Read response payload for both ports, registered together.
    typedef struct packed {
        reg_word_t ra;
        reg_word_t rb;
    } rd_rsp_t;

    // True when exactly one write-select line is asserted.
    function automatic logic is_onehot(input wr_sel_t sel);
        return (sel != '0) && ((sel & (sel - wr_sel_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write-back and operand-read bus between the datapath and the register file.
interface register_file_if
    import regfile_pkg::*;
;
    wr_sel_t   wr_sel;
    logic      wr_en;
    reg_word_t wr_data;
    logic      rd_req;
    reg_addr_t ra_addr;
    reg_addr_t rb_addr;
    reg_word_t ra_data;
    reg_word_t rb_data;
    logic      rd_valid;
    logic      wr_err;

    modport master (
        output wr_sel, wr_en, wr_data, rd_req, ra_addr, rb_addr,
        input  ra_data, rb_data, rd_valid, wr_err
    );

    modport slave (
        input  wr_sel, wr_en, wr_data, rd_req, ra_addr, rb_addr,
        output ra_data, rb_data, rd_valid, wr_err
    );

endinterface

// File: rtl/register_file_reg32.sv
// Single DATA_W storage register with load enable and async active-low clear.
module reg32
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      clr,
    input  logic      load,
    input  reg_word_t d,
    output reg_word_t q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit register file, R0 hardwired to zero, two registered read ports.
// Optional write-first forwarding when REGFILE_BYPASS_EN is defined.
module register_file
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    register_file_if.slave  bus
);

    logic      onehot_ok_c;
    logic      wr_fire_c;
    reg_word_t regs [NREGS];
    rd_rsp_t   rsp_next_c;
    rd_rsp_t   rsp_q;
    logic      rd_valid_q;
    logic      wr_err_q;

    assign onehot_ok_c = is_onehot(bus.wr_sel);
    assign wr_fire_c   = bus.wr_en & onehot_ok_c;

    // R0 is a constant; R1..R31 load only on a clean one-hot write.
    for (genvar k = 0; k < int'(NREGS); k++) begin : g_reg
        if (k == int'(ZERO_REG)) begin : g_zero
            assign regs[k] = '0;
        end else begin : g_store
            reg32 u_reg (
                .clk  (clk),
                .clr  (clr),
                .load (wr_fire_c & bus.wr_sel[k]),
                .d    (bus.wr_data),
                .q    (regs[k])
            );
        end
    end

    // Read muxes, with optional forwarding of the write landing on this edge.
    always_comb begin
        rsp_next_c.ra = regs[bus.ra_addr];
        rsp_next_c.rb = regs[bus.rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire_c && (bus.ra_addr != ZERO_REG) && bus.wr_sel[bus.ra_addr]) begin
            rsp_next_c.ra = bus.wr_data;
        end
        if (wr_fire_c && (bus.rb_addr != ZERO_REG) && bus.wr_sel[bus.rb_addr]) begin
            rsp_next_c.rb = bus.wr_data;
        end
`endif
    end

    // Read response registers; data holds when no request is made.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rsp_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rsp_q <= rsp_next_c;
            end
        end
    end

    // Sticky flag for a strobed write whose select is zero or multi-hot.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_err_q <= 1'b0;
        end else if (bus.wr_en && !onehot_ok_c) begin
            wr_err_q <= 1'b1;
        end
    end

    assign bus.ra_data  = rsp_q.ra;
    assign bus.rb_data  = rsp_q.rb;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_err   = wr_err_q;

endmodule
